// File: rtl/div_bcd_conv.sv
// Serial converter from the divider's unsigned 16.24 quotient to BCD.
// The 16-bit integer part becomes 5 BCD digits through iterative double-dabble.
// The 24-bit fraction becomes 4 truncated BCD digits through repeated multiply-by-10.
// Each step takes one clock.
module div_bcd_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        conv_start,
    input  logic        div_sign,
    input  logic        div_invld,
    input  logic [15:0] div_result_int,
    input  logic [23:0] div_result_frac,
    output logic        conv_busy,
    output logic        conv_done,
    output logic [19:0] bcd_int,
    output logic [15:0] bcd_frac,
    output logic        bcd_neg,
    output logic        bcd_err
);

    typedef enum logic [1:0] {IDLE, INT, FRAC, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [15:0] int_sr, int_sr_nxt;
    logic [19:0] bcd_acc, bcd_acc_nxt;
    logic [23:0] frac_rem, frac_rem_nxt;
    logic [15:0] frac_dig, frac_dig_nxt;
    logic        sign_q, sign_nxt;
    logic        invld_q, invld_nxt;
    logic        load_out;
    logic [19:0] adj_acc;
    logic [27:0] frac_x10;

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] acc);
        logic [19:0] res;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            else
                res[4*i +: 4] = acc[4*i +: 4];
        end
        return res;
    endfunction

    // Remainder times ten. The top nibble is the next decimal digit and is always at most 9.
    function automatic logic [27:0] mul10(input logic [23:0] rem);
        logic [27:0] w;
        w = {4'd0, rem};
        return (w << 3) + (w << 1);
    endfunction

    assign adj_acc   = dabble_adjust(bcd_acc);
    assign frac_x10  = mul10(frac_rem);
    assign conv_busy = (state != IDLE);
    assign conv_done = (state == DONE);

    // Next-state logic and the datapath step for each state.
    // The single INT cycle on the invalid path makes busy last two cycles.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        int_sr_nxt   = int_sr;
        bcd_acc_nxt  = bcd_acc;
        frac_rem_nxt = frac_rem;
        frac_dig_nxt = frac_dig;
        sign_nxt     = sign_q;
        invld_nxt    = invld_q;
        load_out     = 1'b0;
        case (state)
            IDLE: begin
                if (conv_start) begin
                    int_sr_nxt   = div_result_int;
                    frac_rem_nxt = div_result_frac;
                    sign_nxt     = div_sign;
                    invld_nxt    = div_invld;
                    bcd_acc_nxt  = '0;
                    frac_dig_nxt = '0;
                    cnt_nxt      = '0;
                    state_nxt    = INT;
                end
            end
            INT: begin
                if (invld_q) begin
                    load_out  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    {bcd_acc_nxt, int_sr_nxt} = {adj_acc, int_sr} << 1;
                    if (cnt == 5'd15) begin
                        cnt_nxt   = '0;
                        state_nxt = FRAC;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
            end
            FRAC: begin
                frac_dig_nxt = {frac_dig[11:0], frac_x10[27:24]};
                frac_rem_nxt = frac_x10[23:0];
                if (cnt == 5'd3) begin
                    cnt_nxt   = '0;
                    load_out  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, step counter and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            int_sr   <= '0;
            bcd_acc  <= '0;
            frac_rem <= '0;
            frac_dig <= '0;
            sign_q   <= 1'b0;
            invld_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            int_sr   <= int_sr_nxt;
            bcd_acc  <= bcd_acc_nxt;
            frac_rem <= frac_rem_nxt;
            frac_dig <= frac_dig_nxt;
            sign_q   <= sign_nxt;
            invld_q  <= invld_nxt;
        end
    end

    // Result registers load only on entry to DONE; the minus sign is suppressed for an all-zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_int  <= '0;
            bcd_frac <= '0;
            bcd_neg  <= 1'b0;
            bcd_err  <= 1'b0;
        end else if (load_out) begin
            if (invld_q) begin
                bcd_int  <= '0;
                bcd_frac <= '0;
                bcd_neg  <= 1'b0;
                bcd_err  <= 1'b1;
            end else begin
                bcd_int  <= bcd_acc_nxt;
                bcd_frac <= frac_dig_nxt;
                bcd_neg  <= sign_q & ((|bcd_acc_nxt) | (|frac_dig_nxt));
                bcd_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_bcd_conv.sv
// Directed table-driven bench for div_bcd_conv, with hand sequences for ignored starts and mid-conversion reset.
module tb_div_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        conv_start;
    logic        div_sign;
    logic        div_invld;
    logic [15:0] div_result_int;
    logic [23:0] div_result_frac;
    logic        conv_busy;
    logic        conv_done;
    logic [19:0] bcd_int;
    logic [15:0] bcd_frac;
    logic        bcd_neg;
    logic        bcd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] in_int;
        logic [23:0] in_frac;
        logic        in_sign;
        logic        in_invld;
        logic [19:0] exp_int;
        logic [15:0] exp_frac;
        logic        exp_neg;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    div_bcd_conv dut (
        .clk             (clk),
        .rst             (rst),
        .conv_start      (conv_start),
        .div_sign        (div_sign),
        .div_invld       (div_invld),
        .div_result_int  (div_result_int),
        .div_result_frac (div_result_frac),
        .conv_busy       (conv_busy),
        .conv_done       (conv_done),
        .bcd_int         (bcd_int),
        .bcd_frac        (bcd_frac),
        .bcd_neg         (bcd_neg),
        .bcd_err         (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " busy"}, 32'(conv_busy), 32'd0);
        chk({tag, " done"}, 32'(conv_done), 32'd0);
        chk({tag, " bcd_int"}, 32'(bcd_int), 32'd0);
        chk({tag, " bcd_frac"}, 32'(bcd_frac), 32'd0);
        chk({tag, " neg"}, 32'(bcd_neg), 32'd0);
        chk({tag, " err"}, 32'(bcd_err), 32'd0);
    endtask

    // Called at a negedge: issues a start for the next posedge (E0) and follows the conversion until busy drops.
    // With disturb set, operands change every cycle and extra starts are issued at E5 and during DONE.
    task automatic run_conv(input vec_t v, input bit disturb, input string tag);
        int k, busy_n, done_n, lat;
        logic [19:0] got_int;
        logic [15:0] got_frac;
        logic        got_neg, got_err;
        got_int = '0; got_frac = '0; got_neg = 1'b0; got_err = 1'b0;
        div_result_int  = v.in_int;
        div_result_frac = v.in_frac;
        div_sign        = v.in_sign;
        div_invld       = v.in_invld;
        conv_start      = 1'b1;
        busy_n = 0; done_n = 0; lat = -1; k = 0;
        @(negedge clk);
        while (1) begin
            conv_start = 1'b0;
            if (!conv_busy) break;
            if (k >= 40) begin
                chk({tag, " timeout"}, 32'(k), 32'd0);
                break;
            end
            busy_n++;
            if (conv_done) begin
                done_n++;
                if (lat < 0) lat = k;
                got_int = bcd_int; got_frac = bcd_frac;
                got_neg = bcd_neg; got_err = bcd_err;
            end
            if (disturb) begin
                div_result_int  = 16'($urandom);
                div_result_frac = 24'($urandom);
                div_sign        = 1'($urandom);
                div_invld       = 1'($urandom);
                if (k == 4 || conv_done) conv_start = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(lat), v.in_invld ? 32'd1 : 32'd20);
        chk({tag, " busy_cycles"}, 32'(busy_n), v.in_invld ? 32'd2 : 32'd21);
        chk({tag, " done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, " bcd_int"}, 32'(got_int), 32'(v.exp_int));
        chk({tag, " bcd_frac"}, 32'(got_frac), 32'(v.exp_frac));
        chk({tag, " neg"}, 32'(got_neg), 32'(v.exp_neg));
        chk({tag, " err"}, 32'(got_err), 32'(v.exp_err));
        chk({tag, " hold_int"}, 32'(bcd_int), 32'(v.exp_int));
        if (disturb) begin
            @(negedge clk);
            chk({tag, " start_not_queued"}, 32'(conv_busy), 32'd0);
        end
    endtask

    initial begin
        //              int       frac          sign  invld  exp_int    exp_frac  neg   err
        vecs[0] = '{16'h3039, 24'h800000, 1'b0, 1'b0, 20'h12345, 16'h5000, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 24'hFFFFFF, 1'b1, 1'b0, 20'h65535, 16'h9999, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 24'h555555, 1'b1, 1'b0, 20'h00000, 16'h3333, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 24'h000000, 1'b1, 1'b0, 20'h00000, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 24'h000000, 1'b0, 1'b1, 20'h00000, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{16'h1234, 24'hABCDEF, 1'b1, 1'b1, 20'h00000, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{16'h0001, 24'h000000, 1'b1, 1'b0, 20'h00001, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1;
        conv_start = 1'b0;
        div_sign = 1'b0;
        div_invld = 1'b0;
        div_result_int = '0;
        div_result_frac = '0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("idle_after_reset");

        // Consecutive vectors also exercise back-to-back starts in the first IDLE cycle.
        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Extra starts at E5 and during DONE, with operands scrambled after latching.
        run_conv(vecs[0], 1'b1, "ignore_start");

        // Reset asserted just after E10 of a conversion aborts it and clears the outputs.
        div_result_int  = 16'hFFFF;
        div_result_frac = 24'hFFFFFF;
        div_sign        = 1'b1;
        div_invld       = 1'b0;
        conv_start      = 1'b1;
        @(negedge clk);
        conv_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset busy", 32'(conv_busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_outputs_zero("async_reset");
        repeat (3) begin
            @(negedge clk);
            chk("in_reset done", 32'(conv_done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("after_abort");
        run_conv('{16'h000A, 24'h19999A, 1'b0, 1'b0, 20'h00010, 16'h1000, 1'b0, 1'b0}, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
